// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
//
// Shared definitions for the multi-cycle MIPS main control unit:
//   - state_t   : 4-bit FSM state encoding (also exported on the debug port)
//   - OP_*      : opcode values of the supported instruction classes
//   - ALU_OP_*  : alu_op codes consumed by the ALU control unit
//   - SRC_B_*   : ALU B-operand select codes
//   - PC_SRC_*  : next-PC select codes
//   - ctrl_t    : packed control word produced by the state decoder
//   - op_supported() / is_retire() helpers
//
// Configuration macro: MC_CTRL_JUMP_EN (enables the J instruction).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_J      = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SL2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

`ifdef MC_CTRL_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // Everything deasserted; also the word seen in IDLE and during reset.
  localparam ctrl_t CTRL_NONE = '{
    pc_write:      1'b0,
    pc_write_cond: 1'b0,
    i_or_d:        1'b0,
    mem_read:      1'b0,
    mem_write:     1'b0,
    ir_write:      1'b0,
    mem_to_reg:    1'b0,
    reg_dst:       1'b0,
    reg_write:     1'b0,
    alu_src_a:     1'b0,
    alu_src_b:     SRC_B_REG,
    alu_op:        ALU_OP_ADD,
    pc_source:     PC_SRC_ALU,
    illegal:       1'b0
  };

  // True for opcodes that DECODE dispatches to an execute sequence.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_R_TYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: op_supported = 1'b1;
      OP_J:                                    op_supported = JUMP_EN;
      default:                                 op_supported = 1'b0;
    endcase
  endfunction

  // States whose exit to FETCH marks the instruction as retired.
  function automatic logic is_retire(input state_t s);
    is_retire = (s inside {S_R_WB, S_ADDI_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP});
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control_if
//
// Bundle between the multi-cycle control FSM and the datapath.
//   Datapath -> control : op (IR[31:26]), mem_ready
//   Control -> datapath : PC/memory/IR/register-file enables and mux selects,
//                         alu_op, illegal, instr_count, debug state
// Modports:
//   master : the control unit (drives the control word)
//   slave  : the datapath / memory side
// Parameter CNT_W sets the width of instr_count.
// -----------------------------------------------------------------------------
interface mips_multicycle_control_if #(
  parameter int CNT_W = 16
);

  logic [5:0]       op;
  logic             mem_ready;

  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, instr_count, state
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, instr_count, state
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
//
// Purely combinational state -> control-word decoder for the multi-cycle
// MIPS control unit.
//   state     : current FSM state
//   mem_ready : memory handshake; only FETCH looks at it (IR/PC load)
//   op        : opcode, used only in DECODE to flag unsupported opcodes
//   ctrl      : full datapath control word
//
// Configuration macro: MC_CTRL_JUMP_EN (JUMP state decoded only when defined).
// -----------------------------------------------------------------------------
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case, so no path can leave
    // a control bit unassigned and infer a latch.
    ctrl = CTRL_NONE;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR and PC only load on the cycle the instruction word arrives.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // ALUOut <= PC+4 + (imm << 2): branch target computed speculatively.
        ctrl.alu_src_b = SRC_B_IMM_SL2;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.illegal   = ~op_supported(op);
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
//
// Multi-cycle main control unit for the 16-bit MIPS datapath. Sequences
// FETCH / DECODE / execute / memory / write-back so one ALU and one memory
// port are shared across phases.
//
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset (IDLE, counter cleared)
//   bus      : mips_multicycle_control_if.master
//              in : op, mem_ready
//              out: datapath control word, illegal, instr_count, state
// Parameter:
//   CNT_W    : width of the retired-instruction counter (wraps, no saturation)
//
// Configuration macro: MC_CTRL_JUMP_EN -- when defined, opcode 000010 runs the
// JUMP state; otherwise it is treated as an unsupported opcode.
//
// The state register, next-state logic and counter live here; the control
// word is decoded from the state by mc_ctrl_decode.
// -----------------------------------------------------------------------------
module mips_multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  mips_multicycle_control_if.master  bus
);

  state_t           state_q;
  state_t           next_state;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  ctrl_t            ctrl;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_R_TYPE:    next_state = S_R_EXEC;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDI_EXEC;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         next_state = S_JUMP;
`endif
          // Unsupported opcode: abandon the instruction, nothing retires.
          default:      next_state = S_FETCH;
        endcase
      end
      // op is still held from DECODE, so it selects load vs store here.
      S_MEM_ADDR:  next_state = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    if (bus.mem_ready) next_state = S_MEM_WB;
      S_MEM_WR:    if (bus.mem_ready) next_state = S_FETCH;
      S_R_EXEC:    next_state = S_R_WB;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_R_WB, S_ADDI_WB, S_MEM_WB, S_BRANCH:
                   next_state = S_FETCH;
`ifdef MC_CTRL_JUMP_EN
      S_JUMP:      next_state = S_FETCH;
`endif
      // Unused encodings fall back to a clean restart.
      default:     next_state = S_IDLE;
    endcase
  end

  // An instruction retires on the edge that leaves its last state for FETCH.
  // IDLE->FETCH and DECODE->FETCH (unsupported opcode) are excluded by
  // is_retire().
  assign retire = is_retire(state_q) && (next_state == S_FETCH);

  // ---------------------------------------------------------------------------
  // State register and retired-instruction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples the
      // pre-edge value of state_q regardless of statement order.
      state_q <= next_state;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control word
  // ---------------------------------------------------------------------------
  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .op        (bus.op),
    .ctrl      (ctrl)
  );

  // Reset forces state_q to IDLE asynchronously, so the decoded word drops
  // to all-zero in the same cycle and no pending write can complete.
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal       = ctrl.illegal;
  assign bus.instr_count   = count_q;
  assign bus.state         = state_q;

endmodule
